// File: rtl/accumulator_ctrl.sv
// Sequential accumulator stage around an external combinational adder: accepts operands over
// valid/ready, presents acc/operand to the adder, and folds the sum back with overflow tracking.
module accumulator_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             clear,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] sum_in,
    output logic [WIDTH-1:0] acc_out,
    output logic             out_valid,
    output logic             ovf,
    output logic [CNT_W-1:0] count
);

    typedef enum logic [1:0] {StIdle, StPresent, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic               ovf_q, ovf_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        ovf_d       = ovf_q;
        count_d     = count_q;
        out_valid_d = 1'b0;
        unique case (state_q)
            StIdle: begin
                // clear wins over a pending operand, which stays unaccepted
                if (clear) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = '0;
                end else if (in_valid) begin
                    opb_d   = in_data;
                    state_d = StPresent;
                end
            end
            StPresent: begin
                acc_d = sum_in;
                // adder has no carry-out: a wrapped sum is smaller than the old accumulator
                ovf_d = ovf_q | (sum_in < acc_q);
                if (count_q != {CNT_W{1'b1}}) begin
                    count_d = count_q + CNT_W'(1);
                end
                out_valid_d = 1'b1;
                state_d     = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        in_ready_d = (state_d == StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            acc_q       <= '0;
            opb_q       <= '0;
            ovf_q       <= 1'b0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            ovf_q       <= ovf_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign add_a     = acc_q;
    assign add_b     = opb_q;
    assign acc_out   = acc_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;
    assign count     = count_q;

endmodule

// File: tb/tb_accumulator_ctrl.sv
// Directed bench for accumulator_ctrl; models the 4-bit wrapping adder on sum_in.
module tb_accumulator_ctrl;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_data;
    logic       clear;
    logic [3:0] add_a;
    logic [3:0] add_b;
    logic [3:0] sum_in;
    logic [3:0] acc_out;
    logic       out_valid;
    logic       ovf;
    logic [3:0] count;
    logic [4:0] full_sum;

    int vectors;
    int miscompares;

    accumulator_ctrl #(
        .WIDTH(4),
        .CNT_W(4)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .clear    (clear),
        .add_a    (add_a),
        .add_b    (add_b),
        .sum_in   (sum_in),
        .acc_out  (acc_out),
        .out_valid(out_valid),
        .ovf      (ovf),
        .count    (count)
    );

    assign full_sum = {1'b0, add_a} + {1'b0, add_b};
    assign sum_in   = full_sum[3:0];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // From an IDLE negedge: offer d for one cycle, return at the DONE-cycle negedge.
    task automatic do_add(input logic [3:0] d);
        in_valid = 1'b1;
        in_data  = d;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if (acc_out !== 4'd0) begin
            miscompares++; $display("FAIL reset_acc got %0d want 0", acc_out);
        end
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++; $display("FAIL reset_ovf got %0b want 0", ovf);
        end
        vectors++;
        if (count !== 4'd0) begin
            miscompares++; $display("FAIL reset_count got %0d want 0", count);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++; $display("FAIL reset_in_ready got %0b want 1", in_ready);
        end
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL reset_out_valid got %0b want 0", out_valid);
        end
    endtask

    task automatic test_accumulate();
        do_add(4'd3);
        vectors++;
        if (acc_out !== 4'd3 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL acc_first got acc=%0d ov=%0b rdy=%0b want acc=3 ov=1 rdy=0",
                     acc_out, out_valid, in_ready);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL acc_first_pulse got ov=%0b rdy=%0b want ov=0 rdy=1",
                     out_valid, in_ready);
        end
        do_add(4'd4);
        vectors++;
        if (acc_out !== 4'd7 || count !== 4'd2 || ovf !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL acc_second got acc=%0d cnt=%0d ovf=%0b ov=%0b want 7 2 0 1",
                     acc_out, count, ovf, out_valid);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++; $display("FAIL acc_second_pulse got %0b want 0", out_valid);
        end
    endtask

    task automatic test_wrap();
        do_add(4'd2);
        @(negedge clk);
        vectors++;
        if (acc_out !== 4'd9 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_setup got acc=%0d ovf=%0b want 9 0", acc_out, ovf);
        end
        do_add(4'd9);
        vectors++;
        if (acc_out !== 4'd2 || ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_9p9 got acc=%0d ovf=%0b want 2 1", acc_out, ovf);
        end
        @(negedge clk);
        do_add(4'd1);
        vectors++;
        if (acc_out !== 4'd3 || ovf !== 1'b1 || count !== 4'd5) begin
            miscompares++;
            $display("FAIL wrap_sticky got acc=%0d ovf=%0b cnt=%0d want 3 1 5",
                     acc_out, ovf, count);
        end
        @(negedge clk);
    endtask

    task automatic test_hold_valid();
        logic [5:0] rdy_seen;
        int         pulses;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        pulses   = 0;
        in_valid = 1'b1;
        in_data  = 4'd1;
        for (int i = 0; i < 6; i++) begin
            rdy_seen[5-i] = in_ready;
            if (out_valid === 1'b1) pulses++;
            if (i < 5) @(negedge clk);
        end
        in_valid = 1'b0;
        vectors++;
        if (rdy_seen !== 6'b100100) begin
            miscompares++; $display("FAIL hold_ready_pattern got %b want 100100", rdy_seen);
        end
        vectors++;
        if (pulses != 2 || acc_out !== 4'd2 || count !== 4'd2) begin
            miscompares++;
            $display("FAIL hold_accepts got pulses=%0d acc=%0d cnt=%0d want 2 2 2",
                     pulses, acc_out, count);
        end
        @(negedge clk);
    endtask

    task automatic test_clear_priority();
        do_add(4'd15);
        @(negedge clk);
        vectors++;
        if (acc_out !== 4'd1 || ovf !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_setup got acc=%0d ovf=%0b want 1 1", acc_out, ovf);
        end
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'd5;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        vectors++;
        if (acc_out !== 4'd0 || ovf !== 1'b0 || count !== 4'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL clear_state got acc=%0d ovf=%0b cnt=%0d rdy=%0b want 0 0 0 1",
                     acc_out, ovf, count, in_ready);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || acc_out !== 4'd0) begin
            miscompares++;
            $display("FAIL clear_no_accept got ov=%0b acc=%0d want 0 0", out_valid, acc_out);
        end
    endtask

    task automatic test_reset_mid();
        do_add(4'd5);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 4'd3;
        @(negedge clk);
        in_valid = 1'b0;
        reset    = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (out_valid !== 1'b0 || acc_out !== 4'd0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_mid got ov=%0b acc=%0d rdy=%0b want 0 0 1",
                     out_valid, acc_out, in_ready);
        end
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || acc_out !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_mid_after got ov=%0b acc=%0d want 0 0", out_valid, acc_out);
        end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 15; i++) begin
            do_add(4'd0);
            @(negedge clk);
        end
        vectors++;
        if (count !== 4'd15) begin
            miscompares++; $display("FAIL sat_at_max got %0d want 15", count);
        end
        do_add(4'd0);
        vectors++;
        if (count !== 4'd15 || acc_out !== 4'd0 || ovf !== 1'b0 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL sat_hold got cnt=%0d acc=%0d ovf=%0b ov=%0b want 15 0 0 1",
                     count, acc_out, ovf, out_valid);
        end
        @(negedge clk);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        in_valid    = 1'b0;
        in_data     = 4'd0;
        clear       = 1'b0;
        @(negedge clk);
        test_reset();
        test_accumulate();
        test_wrap();
        test_hold_valid();
        test_clear_priority();
        test_reset_mid();
        test_saturate();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
